// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame geometry and the byte
// constants the command accumulator matches against.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreakWait
  } uart_state_e;

  localparam logic [7:0] TERM_BYTE_0   = 8'hBE;
  localparam logic [7:0] TERM_BYTE_1   = 8'hEF;
  localparam logic [7:0] BLE_TERM_BYTE = 8'h0D;

  // Half a bit period, rounded down; START samples the line here.
  function automatic logic [15:0] half_bit(input int unsigned clks_per_bit);
    return 16'(clks_per_bit / 2);
  endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Serial line in, received-byte strobe bus out, for one UART receive link.
interface uart_rx_byte_if;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  // master: line driver and byte consumer; slave: the receiver itself.
  modport master (
    output rx,
    input  data_out,
    input  data_valid,
    input  frame_error,
    input  busy
  );

  modport slave (
    input  rx,
    output data_out,
    output data_valid,
    output frame_error,
    output busy
  );
endinterface

// File: rtl/uart_sync_ff.sv
// Multi-flop synchronizer for an asynchronous, idle-high input; resets to 1
// so a reset never looks like a falling edge on the line.
module uart_sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("uart_sync_ff: SYNC_STAGES must be in 2..4");
  end

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, LSB first, mid-bit sampling; emits a one-cycle strobe per
// good byte and a one-cycle frame_error pulse per bad stop bit.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_byte_if.slave  bus
);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_rx_byte: CLKS_PER_BIT must be in 4..65535");
  end

  localparam logic [15:0] HalfM1   = half_bit(CLKS_PER_BIT) - 16'd1;
  localparam logic [15:0] BitM1    = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LastBit  = 3'(UART_DATA_BITS - 1);

  logic w_rx_s;

  uart_sync_ff #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.rx),
    .o_q   (w_rx_s)
  );

  uart_state_e               r_state, w_state_next;
  logic [15:0]               r_cnt, w_cnt_next;
  logic [2:0]                r_bit_idx, w_bit_idx_next;
  logic [UART_DATA_BITS-1:0] r_shift, w_shift_next;
  logic [UART_DATA_BITS-1:0] r_data_out, w_data_out_next;
  logic                      r_data_valid, w_data_valid_next;
  logic                      r_frame_error, w_frame_error_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_data_out    <= '0;
      r_data_valid  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_bit_idx     <= w_bit_idx_next;
      r_shift       <= w_shift_next;
      r_data_out    <= w_data_out_next;
      r_data_valid  <= w_data_valid_next;
      r_frame_error <= w_frame_error_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt + 16'd1;
    w_bit_idx_next     = r_bit_idx;
    w_shift_next       = r_shift;
    w_data_out_next    = r_data_out;
    w_data_valid_next  = 1'b0;
    w_frame_error_next = 1'b0;

    case (r_state)
      StIdle: begin
        w_cnt_next = '0;
        if (!w_rx_s) begin
          w_state_next = StStart;
        end
      end

      StStart: begin
        if (r_cnt == HalfM1) begin
          w_cnt_next = '0;
          if (!w_rx_s) begin
            w_state_next   = StData;
            w_bit_idx_next = '0;
          end else begin
            w_state_next = StIdle;
          end
        end
      end

      // Counter also restarts between data bits so each sample lands mid-bit.
      StData: begin
        if (r_cnt == BitM1) begin
          w_cnt_next              = '0;
          w_shift_next[r_bit_idx] = w_rx_s;
          w_bit_idx_next          = r_bit_idx + 3'd1;
          if (r_bit_idx == LastBit) begin
            w_state_next = StStop;
          end
        end
      end

      StStop: begin
        if (r_cnt == BitM1) begin
          w_cnt_next = '0;
          if (w_rx_s) begin
            w_data_out_next   = r_shift;
            w_data_valid_next = 1'b1;
            w_state_next      = StIdle;
          end else begin
            w_frame_error_next = 1'b1;
            w_state_next       = StBreakWait;
          end
        end
      end

      // A held-low line must go high before another start bit is accepted.
      StBreakWait: begin
        w_cnt_next = '0;
        if (w_rx_s) begin
          w_state_next = StIdle;
        end
      end

      default: begin
        w_cnt_next   = '0;
        w_state_next = StIdle;
      end
    endcase
  end

  assign bus.data_out    = r_data_out;
  assign bus.data_valid  = r_data_valid;
  assign bus.frame_error = r_frame_error;
  assign bus.busy        = (r_state != StIdle);

endmodule
